// File: rtl/fetch_unit.sv
// PC and fetch stage in front of the combinational instruction ROM; latches the word into IR with a valid flag.
// Latency: one cycle from address to IR. Stall holds PC and IR; a branch or halt squashes the word fetched that cycle.
module fetch_unit #(
    parameter int rom_size    = 256,
    parameter int instr_width = 9,
    parameter int addr_width  = $clog2(rom_size) + 1,
    parameter int off_width   = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [addr_width-1:0]  start_addr,
    input  logic                   stall,
    input  logic                   branch_en,
    input  logic                   branch_abs,
    input  logic [addr_width-1:0]  branch_target,
    input  logic [off_width-1:0]   branch_offset,
    input  logic                   halt_req,
    output logic [addr_width-1:0]  instr_addr,
    input  logic [instr_width-1:0] instr_in,
    output logic [instr_width-1:0] ir_out,
    output logic [addr_width-1:0]  ir_pc,
    output logic                   ir_valid,
    output logic                   running,
    output logic                   done,
    output logic                   fault
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    localparam logic [addr_width-1:0] last_addr = addr_width'(rom_size - 1);

    state_t                 state, state_nx;
    logic [addr_width-1:0]  pc, pc_nx, ir_pc_nx;
    logic [instr_width-1:0] ir_nx;
    logic                   ir_valid_nx, done_nx, fault_nx;
    logic [addr_width-1:0]  rel_target, target;
    logic                   target_ok;

    // Relative targets wrap modulo 2^addr_width; the spare top bit makes wraps land out of range.
    assign rel_target = ir_pc + {{(addr_width-off_width){branch_offset[off_width-1]}}, branch_offset};
    assign target     = branch_abs ? branch_target : rel_target;
    assign target_ok  = (target <= last_addr);

    assign instr_addr = pc;
    assign running    = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        ir_nx       = ir_out;
        ir_pc_nx    = ir_pc;
        ir_valid_nx = 1'b0;
        done_nx     = done;
        fault_nx    = fault;
        case (state)
            RUN: begin
                if (halt_req) begin
                    done_nx  = 1'b1;
                    state_nx = HALTED;
                end else if (branch_en) begin
                    if (target_ok) begin
                        pc_nx = target;
                    end else begin
                        fault_nx = 1'b1;
                        done_nx  = 1'b1;
                        state_nx = HALTED;
                    end
                end else if (stall) begin
                    ir_valid_nx = ir_valid;
                end else begin
                    ir_nx       = instr_in;
                    ir_pc_nx    = pc;
                    ir_valid_nx = 1'b1;
                    if (pc == last_addr) begin
                        done_nx  = 1'b1;
                        state_nx = HALTED;
                    end else begin
                        pc_nx = pc + addr_width'(1);
                    end
                end
            end
            default: begin
                if (start) begin
                    pc_nx    = start_addr;
                    done_nx  = 1'b0;
                    fault_nx = 1'b0;
                    state_nx = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            ir_out   <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            pc       <= pc_nx;
            ir_out   <= ir_nx;
            ir_pc    <= ir_pc_nx;
            ir_valid <= ir_valid_nx;
            done     <= done_nx;
            fault    <= fault_nx;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a ROM model rom[k] = k + 0x100.
module tb_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [8:0] start_addr;
    logic       stall;
    logic       branch_en;
    logic       branch_abs;
    logic [8:0] branch_target;
    logic [5:0] branch_offset;
    logic       halt_req;
    logic [8:0] instr_addr;
    logic [8:0] instr_in;
    logic [8:0] ir_out;
    logic [8:0] ir_pc;
    logic       ir_valid;
    logic       running;
    logic       done;
    logic       fault;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .stall(stall), .branch_en(branch_en), .branch_abs(branch_abs),
        .branch_target(branch_target), .branch_offset(branch_offset),
        .halt_req(halt_req), .instr_addr(instr_addr), .instr_in(instr_in),
        .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid),
        .running(running), .done(done), .fault(fault)
    );

    assign instr_in = 9'h100 + instr_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       st;
        logic [8:0] saddr;
        logic       stl;
        logic       ben;
        logic       babs;
        logic [8:0] btgt;
        logic [5:0] boff;
        logic       hlt;
        logic [8:0] e_addr;
        logic [8:0] e_ir;
        logic [8:0] e_irpc;
        logic       e_vld;
        logic       e_run;
        logic       e_done;
        logic       e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic [8:0] saddr, logic stl, logic ben, logic babs,
                                logic [8:0] btgt, logic [5:0] boff, logic hlt,
                                logic [8:0] ea, logic [8:0] ei, logic [8:0] ep,
                                logic ev, logic er, logic ed, logic ef);
        vec_t v;
        v.st = st; v.saddr = saddr; v.stl = stl; v.ben = ben; v.babs = babs;
        v.btgt = btgt; v.boff = boff; v.hlt = hlt;
        v.e_addr = ea; v.e_ir = ei; v.e_irpc = ep;
        v.e_vld = ev; v.e_run = er; v.e_done = ed; v.e_fault = ef;
        return v;
    endfunction

    task automatic check(string name, logic [8:0] ea, logic [8:0] ei, logic [8:0] ep,
                         logic ev, logic er, logic ed, logic ef);
        logic [30:0] got, exp;
        got = {instr_addr, ir_out, ir_pc, ir_valid, running, done, fault};
        exp = {ea, ei, ep, ev, er, ed, ef};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got addr=%0d ir=%h irpc=%0d vld=%b run=%b done=%b fault=%b, want addr=%0d ir=%h irpc=%0d vld=%b run=%b done=%b fault=%b",
                     name, instr_addr, ir_out, ir_pc, ir_valid, running, done, fault,
                     ea, ei, ep, ev, er, ed, ef);
        end
    endtask

    task automatic idle_inputs();
        start = 0; start_addr = 0; stall = 0; branch_en = 0; branch_abs = 0;
        branch_target = 0; branch_offset = 0; halt_req = 0;
    endtask

    initial begin
        //        st saddr stl ben abs tgt  off    hlt | addr ir      irpc v  r  d  f
        vecs.push_back(mk(0, 0,   1, 1, 1, 5,   0,     1,  0,   9'h000, 0,   0, 0, 0, 0)); // idle ignores all
        vecs.push_back(mk(1, 0,   0, 0, 0, 0,   0,     0,  0,   9'h000, 0,   0, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  1,   9'h100, 0,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  2,   9'h101, 1,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  3,   9'h102, 2,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  4,   9'h103, 3,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  5,   9'h104, 4,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   1, 0, 0, 0,   0,     0,  5,   9'h104, 4,   1, 1, 0, 0)); // stall x3
        vecs.push_back(mk(0, 0,   1, 0, 0, 0,   0,     0,  5,   9'h104, 4,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   1, 0, 0, 0,   0,     0,  5,   9'h104, 4,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  6,   9'h105, 5,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  7,   9'h106, 6,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  8,   9'h107, 7,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  9,   9'h108, 8,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  10,  9'h109, 9,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  11,  9'h10A, 10,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 1, 0, 0,   6'h3C, 0,  6,   9'h10A, 10,  0, 1, 0, 0)); // rel -4
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  7,   9'h106, 6,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   1, 1, 1, 200, 0,     0,  200, 9'h106, 6,   0, 1, 0, 0)); // abs + stall
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  201, 9'h1C8, 200, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 1, 1, 50,  0,     1,  201, 9'h1C8, 200, 0, 0, 1, 0)); // halt beats branch
        vecs.push_back(mk(0, 0,   1, 1, 1, 5,   0,     0,  201, 9'h1C8, 200, 0, 0, 1, 0));
        vecs.push_back(mk(1, 254, 0, 0, 0, 0,   0,     0,  254, 9'h1C8, 200, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  255, 9'h1FE, 254, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  255, 9'h1FF, 255, 1, 0, 1, 0)); // last word
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  255, 9'h1FF, 255, 0, 0, 1, 0));
        vecs.push_back(mk(1, 20,  0, 0, 0, 0,   0,     0,  20,  9'h1FF, 255, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  21,  9'h114, 20,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 1, 1, 300, 0,     0,  21,  9'h114, 20,  0, 0, 1, 1)); // out of range
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  21,  9'h114, 20,  0, 0, 1, 1));
        vecs.push_back(mk(1, 3,   0, 0, 0, 0,   0,     0,  3,   9'h114, 20,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  4,   9'h103, 3,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 1, 1, 2,   0,     0,  2,   9'h103, 3,   0, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  3,   9'h102, 2,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 1, 0, 0,   6'h3D, 0,  3,   9'h102, 2,   0, 0, 1, 1)); // 2-3 wraps to 511
        vecs.push_back(mk(1, 7,   0, 0, 0, 0,   0,     0,  7,   9'h102, 2,   0, 1, 0, 0));
        vecs.push_back(mk(1, 100, 0, 0, 0, 0,   0,     0,  8,   9'h107, 7,   1, 1, 0, 0)); // start ignored in RUN
        vecs.push_back(mk(0, 0,   0, 1, 0, 0,   6'h05, 0,  12,  9'h107, 7,   0, 1, 0, 0)); // rel +5
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0,     0,  13,  9'h10C, 12,  1, 1, 0, 0));

        idle_inputs();
        rst_n = 1'b0;
        #2;
        check("reset_state", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            start         = vecs[i].st;
            start_addr    = vecs[i].saddr;
            stall         = vecs[i].stl;
            branch_en     = vecs[i].ben;
            branch_abs    = vecs[i].babs;
            branch_target = vecs[i].btgt;
            branch_offset = vecs[i].boff;
            halt_req      = vecs[i].hlt;
            @(posedge clk);
            #1;
            check($sformatf("row%0d", i), vecs[i].e_addr, vecs[i].e_ir, vecs[i].e_irpc,
                  vecs[i].e_vld, vecs[i].e_run, vecs[i].e_done, vecs[i].e_fault);
        end

        // Asynchronous reset between edges while running at pc=13.
        idle_inputs();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", 0, 0, 0, 0, 0, 0, 0);
        start      = 1'b1;
        start_addr = 9'd100;
        @(posedge clk);
        #1;
        check("start_during_reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        check("idle_after_reset", 0, 0, 0, 0, 0, 0, 0);
        start      = 1'b1;
        start_addr = 9'd9;
        @(posedge clk);
        #1;
        check("restart", 9, 0, 0, 0, 1, 0, 0);
        idle_inputs();
        @(posedge clk);
        #1;
        check("restart_fetch", 10, 9'h109, 9, 1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
